// File: rtl/vx_mrp_dp_ram.sv
// vx_mrp_dp_ram: multi-read-port, single-write-port synchronous RAM with byte enables,
// selectable read-during-write data and an optional fill-on-reset/clear sequencer.
module vx_mrp_dp_ram #(
    parameter int               DATAW      = 32,
    parameter int               SIZE       = 64,
    parameter int               BYTEENW    = 1,
    parameter int               NUM_RPORTS = 2,
    parameter int               OUT_REG    = 0,
    parameter int               RW_MODE    = 0,
    parameter int               INIT_CLEAR = 1,
    parameter logic [DATAW-1:0] INIT_VALUE = '0,
    localparam int              ADDRW      = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        clear,
    output logic                        init_busy,
    input  logic                        wr_en,
    input  logic [BYTEENW-1:0]          wr_byteen,
    input  logic [ADDRW-1:0]            waddr,
    input  logic [DATAW-1:0]            wdata,
    input  logic [NUM_RPORTS-1:0]       rd_en,
    input  logic [NUM_RPORTS*ADDRW-1:0] raddr,
    output logic [NUM_RPORTS-1:0]       rd_valid,
    output logic [NUM_RPORTS*DATAW-1:0] rdata
);
    localparam int LANEW = DATAW / BYTEENW;
    localparam logic [ADDRW:0] SIZE_C = (ADDRW + 1)'(SIZE);

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t                      state_q, state_d;
    logic [ADDRW-1:0]            cnt_q, cnt_d;
    logic [DATAW-1:0]            mem [SIZE];
    logic                        init, we;
    logic [ADDRW-1:0]            wa;
    logic [DATAW-1:0]            wd, wmask;
    logic [ADDRW-1:0]            ra [NUM_RPORTS];
    logic [DATAW-1:0]            old_w [NUM_RPORTS];
    logic [NUM_RPORTS-1:0]       rv1_q, rv1_d, rv2_q, rv2_d;
    logic [NUM_RPORTS*DATAW-1:0] rd1_q, rd1_d, rd2_q, rd2_d;

    assign init = state_q == ST_INIT;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (INIT_CLEAR != 0 && clear) begin
            state_d = ST_INIT;
            cnt_d   = '0;
        end else if (init) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == ADDRW'(SIZE - 1)) begin
                state_d = ST_READY;
                cnt_d   = '0;
            end
        end
    end

    // The clear sequencer owns the write port while in INIT.
    always_comb begin
        we = resetn && (init || (wr_en && {1'b0, waddr} < SIZE_C));
        wa = init ? cnt_q : waddr;
        wd = init ? INIT_VALUE : wdata;
        for (int i = 0; i < DATAW; i++) wmask[i] = init || wr_byteen[i / LANEW];
    end

    always_ff @(posedge clk) begin
        if (we) mem[wa] <= (mem[wa] & ~wmask) | (wd & wmask);
    end

    always_comb begin
        rv1_d = '0;
        rd1_d = rd1_q;
        rv2_d = rv1_q;
        rd2_d = rd2_q;
        for (int p = 0; p < NUM_RPORTS; p++) begin
            ra[p]    = raddr[p*ADDRW +: ADDRW];
            old_w[p] = ({1'b0, ra[p]} < SIZE_C) ? mem[ra[p]] : '0;
            rv1_d[p] = !init && rd_en[p];
            // Forwarding only matters for in-range addresses, since we is never set otherwise.
            if (rv1_d[p])
                rd1_d[p*DATAW +: DATAW] = (RW_MODE != 0 && we && wa == ra[p]) ?
                    ((old_w[p] & ~wmask) | (wd & wmask)) : old_w[p];
            if (rv1_q[p]) rd2_d[p*DATAW +: DATAW] = rd1_q[p*DATAW +: DATAW];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= (INIT_CLEAR != 0) ? ST_INIT : ST_READY;
            cnt_q   <= '0;
            rv1_q   <= '0;
            rv2_q   <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rv1_q   <= rv1_d;
            rv2_q   <= rv2_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
        end
    end

    assign init_busy = init;
    assign rd_valid  = (OUT_REG != 0) ? rv2_q : rv1_q;
    assign rdata     = (OUT_REG != 0) ? rd2_q : rd1_q;
endmodule
